usb_tx_data_buffer: RTL and testbench

Byte FIFO directly upstream of the USB transmitter. It stores payload bytes written by the host-side interface and presents them in order on TX_Packet_Data. It reports fill level on Buffer_Occupancy, which the TX packet compiler uses to size DATA packets. The compiler pops one byte per Get_TX_Packet_Data strobe.

---
 rtl/usb_tx_data_buffer_pkg.sv | 10 +
 rtl/usb_tx_data_buffer_if.sv | 26 ++
 rtl/usb_tx_data_buffer_mem.sv | 28 ++
 rtl/usb_tx_data_buffer.sv | 99 +++++++++
 tb/tb_usb_tx_data_buffer.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/usb_tx_data_buffer_pkg.sv
// Shared sizing constants for the USB TX data path.
package usb_tx_pkg;

    localparam int TX_BUF_DEPTH = 64;
    localparam int TX_BUF_AW    = 6;
    localparam int TX_OCC_W     = 7;

    typedef logic [7:0] tx_byte_t;

endpackage

// File: rtl/usb_tx_data_buffer_if.sv
// Host/compiler-facing signal bundle of the TX data buffer.
interface usb_tx_data_buffer_if;
    import usb_tx_pkg::*;

    logic                Store_TX_Data;
    tx_byte_t            TX_Data_In;
    logic                Get_TX_Packet_Data;
    logic                Clear;
    tx_byte_t            TX_Packet_Data;
    logic [TX_OCC_W-1:0] Buffer_Occupancy;
    logic                Full;
    logic                Empty;
    logic                Overflow;
    logic                Underflow;

    modport master (
        output Store_TX_Data, TX_Data_In, Get_TX_Packet_Data, Clear,
        input  TX_Packet_Data, Buffer_Occupancy, Full, Empty, Overflow, Underflow
    );

    modport slave (
        input  Store_TX_Data, TX_Data_In, Get_TX_Packet_Data, Clear,
        output TX_Packet_Data, Buffer_Occupancy, Full, Empty, Overflow, Underflow
    );

endinterface

// File: rtl/usb_tx_data_buffer_mem.sv
// DEPTH x 8 storage with one write port and a combinational read address;
// kept separate so it can be swapped for a RAM macro.
module usb_tx_buf_mem
    import usb_tx_pkg::*;
#(
    parameter int DEPTH = TX_BUF_DEPTH,
    parameter int AW    = TX_BUF_AW
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  tx_byte_t      wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output tx_byte_t      rd_data_o
);

    tx_byte_t memArray_q [DEPTH];

    // Contents are deliberately not reset; occupancy gates what is visible.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            memArray_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = memArray_q[rd_addr_i];

endmodule

// File: rtl/usb_tx_data_buffer.sv
// Show-ahead byte FIFO feeding the USB TX packet compiler.
// Define USB_TX_BUF_STICKY_ERR_EN to make Overflow/Underflow sticky until Clear or reset.
module usb_tx_data_buffer
    import usb_tx_pkg::*;
#(
    parameter int DEPTH = TX_BUF_DEPTH,
    parameter int AW    = TX_BUF_AW
) (
    input  logic                 clk,
    input  logic                 n_rst,
    usb_tx_data_buffer_if.slave  bus
);

    localparam logic [TX_OCC_W-1:0] FULL_COUNT = TX_OCC_W'(DEPTH);

    logic [AW-1:0]       wrPtr_q, wrPtr_d;
    logic [AW-1:0]       rdPtr_q, rdPtr_d;
    logic [TX_OCC_W-1:0] count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic                pushAcc, popAcc, overflowEvt, underflowEvt;
    logic                memWrEn;
    tx_byte_t            headByte;

    // A full FIFO still takes a push when the same cycle frees a slot.
    always_comb begin
        popAcc       = bus.Get_TX_Packet_Data && (count_q != '0);
        pushAcc      = bus.Store_TX_Data && ((count_q != FULL_COUNT) || popAcc);
        overflowEvt  = bus.Store_TX_Data && !pushAcc;
        underflowEvt = bus.Get_TX_Packet_Data && (count_q == '0);
        wrPtr_d      = wrPtr_q;
        rdPtr_d      = rdPtr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;

        if (bus.Clear) begin
            wrPtr_d     = '0;
            rdPtr_d     = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (pushAcc) wrPtr_d = wrPtr_q + 1'b1;
            if (popAcc)  rdPtr_d = rdPtr_q + 1'b1;
            case ({pushAcc, popAcc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
`ifdef USB_TX_BUF_STICKY_ERR_EN
            overflow_d  = overflow_q  | overflowEvt;
            underflow_d = underflow_q | underflowEvt;
`else
            overflow_d  = overflowEvt;
            underflow_d = underflowEvt;
`endif
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign memWrEn = pushAcc && !bus.Clear;

    usb_tx_buf_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (memWrEn),
        .wr_addr_i (wrPtr_q),
        .wr_data_i (bus.TX_Data_In),
        .rd_addr_i (rdPtr_q),
        .rd_data_o (headByte)
    );

    // Stale storage must never leak out, so an empty FIFO shows zero.
    assign bus.TX_Packet_Data   = (count_q != '0) ? headByte : 8'h00;
    assign bus.Buffer_Occupancy = count_q;
    assign bus.Full             = (count_q == FULL_COUNT);
    assign bus.Empty            = (count_q == '0);
    assign bus.Overflow         = overflow_q;
    assign bus.Underflow        = underflow_q;

endmodule

// File: tb/tb_usb_tx_data_buffer.sv
// Scoreboard bench for usb_tx_data_buffer: a queue-based reference model predicts each
// cycle's outputs, and a separate monitor compares them against the DUT.
module tb_usb_tx_data_buffer;
    import usb_tx_pkg::*;

    typedef struct {
        logic [7:0] occ;
        logic [7:0] head;
        logic [7:0] full;
        logic [7:0] empty;
        logic [7:0] ovf;
        logic [7:0] unf;
    } exp_t;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   checkCount = 0;
    int   passCount = 0;

    logic [7:0] model[$];
    logic       ovfM = 1'b0;
    logic       unfM = 1'b0;
    exp_t       expQ[$];

    usb_tx_data_buffer_if bus();

    usb_tx_data_buffer dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: inputs change on the falling edge, the model predicts
    // what the outputs must be after the following rising edge.
    task automatic applyStimulus(input logic st, input logic [7:0] d, input logic gt, input logic clr);
        logic popOk, pushOk, newOvf, newUnf;
        exp_t e;
        @(negedge clk);
        bus.Store_TX_Data      = st;
        bus.TX_Data_In         = d;
        bus.Get_TX_Packet_Data = gt;
        bus.Clear              = clr;
        if (clr) begin
            model.delete();
            ovfM = 1'b0;
            unfM = 1'b0;
        end else begin
            popOk  = gt && (model.size() > 0);
            pushOk = st && ((model.size() < TX_BUF_DEPTH) || popOk);
            newOvf = st && !pushOk;
            newUnf = gt && (model.size() == 0);
            if (popOk)  void'(model.pop_front());
            if (pushOk) model.push_back(d);
`ifdef USB_TX_BUF_STICKY_ERR_EN
            ovfM = ovfM | newOvf;
            unfM = unfM | newUnf;
`else
            ovfM = newOvf;
            unfM = newUnf;
`endif
        end
        e.occ   = 8'(model.size());
        e.head  = (model.size() > 0) ? model[0] : 8'h00;
        e.full  = {7'd0, model.size() == TX_BUF_DEPTH};
        e.empty = {7'd0, model.size() == 0};
        e.ovf   = {7'd0, ovfM};
        e.unf   = {7'd0, unfM};
        expQ.push_back(e);
    endtask

    task automatic checkResetState();
        checkOutput("rstOccupancy", {1'b0, bus.Buffer_Occupancy}, 8'd0);
        checkOutput("rstHead", bus.TX_Packet_Data, 8'h00);
        checkOutput("rstEmpty", {7'd0, bus.Empty}, 8'd1);
        checkOutput("rstFull", {7'd0, bus.Full}, 8'd0);
        checkOutput("rstOverflow", {7'd0, bus.Overflow}, 8'd0);
        checkOutput("rstUnderflow", {7'd0, bus.Underflow}, 8'd0);
    endtask

    // Monitor: every rising edge with a pending prediction is compared.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("occupancy", {1'b0, bus.Buffer_Occupancy}, e.occ);
                checkOutput("head", bus.TX_Packet_Data, e.head);
                checkOutput("full", {7'd0, bus.Full}, e.full);
                checkOutput("empty", {7'd0, bus.Empty}, e.empty);
                checkOutput("overflow", {7'd0, bus.Overflow}, e.ovf);
                checkOutput("underflow", {7'd0, bus.Underflow}, e.unf);
            end
        end
    end

    initial begin
        int pPush[4] = '{85, 20, 50, 95};
        int pPop[4]  = '{15, 80, 50, 60};
        bus.Store_TX_Data      = 1'b0;
        bus.TX_Data_In         = 8'h00;
        bus.Get_TX_Packet_Data = 1'b0;
        bus.Clear              = 1'b0;
        #1;
        checkResetState();
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;

        applyStimulus(1, 8'hA5, 0, 0);
        applyStimulus(1, 8'h3C, 0, 0);
        applyStimulus(0, 8'h00, 0, 0);
        applyStimulus(0, 8'h00, 1, 0);
        applyStimulus(0, 8'h00, 1, 0);

        for (int i = 0; i < 64; i++) applyStimulus(1, 8'(i), 0, 0);
        applyStimulus(1, 8'h40, 0, 0);
        applyStimulus(0, 8'h00, 0, 0);
        for (int i = 0; i < 64; i++) applyStimulus(0, 8'h00, 1, 0);

        for (int i = 0; i < 64; i++) applyStimulus(1, 8'(i + 8'h80), 0, 0);
        applyStimulus(1, 8'hFF, 1, 0);
        for (int i = 0; i < 64; i++) applyStimulus(0, 8'h00, 1, 0);

        applyStimulus(0, 8'h00, 1, 0);
        applyStimulus(0, 8'h00, 0, 0);
        applyStimulus(1, 8'h11, 1, 0);
        applyStimulus(0, 8'h00, 0, 0);

        for (int i = 0; i < 10; i++) applyStimulus(1, 8'(8'h20 + i), 0, 0);
        applyStimulus(1, 8'h77, 0, 1);
        applyStimulus(0, 8'h00, 0, 0);

        for (int i = 0; i < 65; i++) applyStimulus(1, 8'(i * 3), 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 8'h00, 0, 0);
        applyStimulus(0, 8'h00, 0, 1);
        applyStimulus(0, 8'h00, 0, 0);

        for (int i = 0; i < 20; i++) applyStimulus(1, 8'(i + 8'h50), 0, 0);
        applyStimulus(0, 8'h00, 0, 0);
        @(negedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        checkResetState();
        model.delete();
        ovfM = 1'b0;
        unfM = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;

        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 150; i++) begin
                applyStimulus($urandom_range(0, 99) < pPush[p],
                              8'($urandom_range(0, 255)),
                              $urandom_range(0, 99) < pPop[p],
                              $urandom_range(0, 199) == 0);
            end
        end

        applyStimulus(0, 8'h00, 0, 0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("scoreboardDrained", 8'(expQ.size()), 8'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
